// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Contents:
//   PARITY_NONE/EVEN/ODD  values accepted by the PARITY parameter
//   rx_state_e            receiver FSM encoding (also driven out on state_out)
//   majority3             2-of-3 vote used by the bit sampler
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: input synchroniser, per-bit tick counter
// and 3-sample majority vote.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ena        clock enable; low freezes every flop here
//   rx         raw asynchronous serial line
//   clear      hold the tick counter at 0 on the next enabled edge (FSM heading to IDLE)
//   rx_s       synchronised line
//   vote       majority of the samples at t=M-1, M and the live rx_s at t=M+1
//   decide     high while t=M+1 (vote is valid this cycle)
//   advance    high while t=OVERSAMPLE-1 (last tick of the bit)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic rx,
  input  logic clear,
  output logic rx_s,
  output logic vote,
  output logic decide,
  output logic advance
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_FIRST = TW'(M - 1);
  localparam logic [TW-1:0] T_MID   = TW'(M);
  localparam logic [TW-1:0] T_DEC   = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic [TW-1:0] tick;
  logic          samp_a;
  logic          samp_b;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else if (ena) begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Tick counter: sits at 0 while the FSM is idle, so the cycle that sees the
  // start edge is t=0 and the next one is t=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
    end else if (ena) begin
      if (clear || tick == T_LAST) begin
        tick <= '0;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // The first two samples are stored; the third is the live line at t=M+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (ena) begin
      if (tick == T_FIRST) begin
        samp_a <= rx_s;
      end
      if (tick == T_MID) begin
        samp_b <= rx_s;
      end
    end
  end

  assign vote    = majority3(samp_a, samp_b, rx_s);
  assign decide  = (tick == T_DEC);
  assign advance = (tick == T_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   ena         clock enable; low freezes all state and ignores rx_ready
//   rx          asynchronous serial line (idle high, start bit low)
//   rx_data     received word, LSB first on the line, stable while rx_valid
//   rx_valid    word available, held until accepted
//   rx_ready    consumer accepts on an edge with rx_valid & rx_ready & ena
//   parity_err  parity mismatch for rx_data (0 when PARITY is none)
//   frame_err   some stop bit of rx_data's frame sampled low
//   overrun     one-cycle pulse when a finished frame found rx_valid still held
//   state_out   current FSM state for debug
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 7,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_out
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  // Elaboration-time guards on the parameter ranges the datapath is built for.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and 4..16");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  rx_state_e state;
  rx_state_e next_state;

  logic                 rx_s;
  logic                 vote;
  logic                 decide;
  logic                 advance;
  logic                 clear_tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 frm_acc;
  logic                 sample_data;
  logic                 sample_parity;
  logic                 sample_stop;
  logic                 stop_last;
  logic                 frame_done;

  assign clear_tick = (next_state == ST_IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .rx     (rx),
    .clear  (clear_tick),
    .rx_s   (rx_s),
    .vote   (vote),
    .decide (decide),
    .advance(advance)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= next_state;
    end
  end

  // Next-state logic. The last stop bit returns to IDLE at its decision point
  // rather than at its end, so a back-to-back start edge is never missed.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (decide && vote) begin
          next_state = ST_IDLE;
        end else if (advance) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (advance && bit_cnt == LAST_BIT) begin
          next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (advance) begin
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide && bit_cnt == LAST_STOP) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output/strobe decode for the datapath below.
  always_comb begin
    state_out     = state;
    sample_data   = 1'b0;
    sample_parity = 1'b0;
    sample_stop   = 1'b0;
    stop_last     = 1'b0;
    frame_done    = 1'b0;
    if (ena) begin
      sample_data   = (state == ST_DATA)   && decide;
      sample_parity = (state == ST_PARITY) && decide;
      sample_stop   = (state == ST_STOP)   && decide;
    end
    stop_last  = (state == ST_STOP) && (bit_cnt == LAST_STOP);
    frame_done = sample_stop && stop_last;
  end

  // Bit counter: counts data bits, is back at 0 through PARITY and then
  // counts stop bits. It never moves on the last stop bit, which exits early.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (ena) begin
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (state == ST_DATA && advance) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end else if (state == ST_STOP && advance && !stop_last) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Shift register fills from the MSB end so LSB-first bits land in place
  // after DATA_BITS shifts. Parity and framing accumulators clear while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      par_acc <= 1'b0;
      frm_acc <= 1'b0;
    end else if (ena) begin
      if (state == ST_IDLE) begin
        par_acc <= 1'b0;
        frm_acc <= 1'b0;
      end
      if (sample_data) begin
        shreg <= {vote, shreg[DATA_BITS-1:1]};
      end
      if (sample_parity) begin
        par_acc <= ((^shreg) ^ vote) != (PARITY == PARITY_ODD);
      end
      if (sample_stop && !vote) begin
        frm_acc <= 1'b1;
      end
    end
  end

  // Output holding register and handshake. A completed frame may reload on
  // the same edge the previous word is accepted; otherwise it is dropped and
  // flagged with a one-cycle overrun pulse, leaving the held word untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (ena) begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_acc;
          frame_err  <= frm_acc | ~vote;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
